// File: rtl/audio_pkg.sv
// Shared audio-path types and constants for the codec output stage.
// Used by the crossfade FSM and its mixing pipeline.
package audio_pkg;

    localparam int AUDIO_W = 24;

    typedef enum logic [1:0] {
        BYPASS,
        FADE_IN,
        FILTERED,
        FADE_OUT
    } xfade_state_t;

    function automatic int full_count(input int log2);
        return 1 << log2;
    endfunction

endpackage

// File: rtl/xfade_mac.sv
// Two-stage dry/wet mixer: out = dry + ((wet - dry) * g) >>> FADE_LOG2.
// Stage 1 registers dry and the product, stage 2 adds the scaled difference.
module xfade_mac
    import audio_pkg::*;
#(
    parameter int W         = AUDIO_W,
    parameter int FADE_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic signed [W-1:0]   dry,
    input  logic signed [W-1:0]   wet,
    input  logic [FADE_LOG2:0]    g,
    output logic signed [W-1:0]   out,
    output logic                  out_valid
);

    localparam int PW = W + FADE_LOG2 + 2;

    logic signed [W:0]    diff;
    logic signed [PW-1:0] diff_x;
    logic signed [PW-1:0] g_x;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_q;
    logic signed [W-1:0]  dry_q;
    logic signed [PW-1:0] dry_x;
    logic                 v1;

    assign diff   = {wet[W-1], wet} - {dry[W-1], dry};
    assign diff_x = {{(PW-W-1){diff[W]}}, diff};
    assign g_x    = {{(PW-FADE_LOG2-1){1'b0}}, g};
    assign prod   = diff_x * g_x;
    assign dry_x  = {{(PW-W){dry_q[W-1]}}, dry_q};

    // The mix is a convex combination, so the low W bits are exact.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
            dry_q     <= '0;
            prod_q    <= '0;
            out       <= '0;
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
            if (in_valid) begin
                dry_q  <= dry;
                prod_q <= prod;
            end
            if (v1) begin
                out <= W'(dry_x + (prod_q >>> FADE_LOG2));
            end
        end
    end

endmodule

// File: rtl/bypass_crossfade.sv
// Click-free dry/wet switch: ramps the wet gain one step per codec sample
// whenever the enable request differs from the settled state.
module bypass_crossfade
    import audio_pkg::*;
#(
    parameter int W         = AUDIO_W,
    parameter int FADE_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_trig,
    input  logic                  enable,
    input  logic signed [W-1:0]   dry_in,
    input  logic signed [W-1:0]   wet_in,
    output logic signed [W-1:0]   data_out,
    output logic                  out_valid,
    output logic                  fading,
    output logic [FADE_LOG2:0]    gain
);

    localparam logic [FADE_LOG2:0] FULL  =
        (FADE_LOG2+1)'(full_count(FADE_LOG2));
    localparam logic [FADE_LOG2:0] G_ONE = (FADE_LOG2+1)'(1);

    xfade_state_t       state;
    logic [FADE_LOG2:0] g_up;
    logic [FADE_LOG2:0] g_dn;

    assign g_up = gain + G_ONE;
    assign g_dn = gain - G_ONE;

    // The mixer sees the gain before this trigger's update.
    xfade_mac #(
        .W         (W),
        .FADE_LOG2 (FADE_LOG2)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (sample_trig),
        .dry       (dry_in),
        .wet       (wet_in),
        .g         (gain),
        .out       (data_out),
        .out_valid (out_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= BYPASS;
            gain   <= '0;
            fading <= 1'b0;
        end else if (sample_trig) begin
            unique case (state)
                BYPASS: begin
                    if (enable) begin
                        gain   <= G_ONE;
                        state  <= FADE_IN;
                        fading <= 1'b1;
                    end
                end
                FILTERED: begin
                    if (!enable) begin
                        gain   <= FULL - G_ONE;
                        state  <= FADE_OUT;
                        fading <= 1'b1;
                    end
                end
                FADE_IN, FADE_OUT: begin
                    if (enable) begin
                        gain <= g_up;
                        if (g_up == FULL) begin
                            state  <= FILTERED;
                            fading <= 1'b0;
                        end else begin
                            state  <= FADE_IN;
                            fading <= 1'b1;
                        end
                    end else begin
                        gain <= g_dn;
                        if (g_dn == '0) begin
                            state  <= BYPASS;
                            fading <= 1'b0;
                        end else begin
                            state  <= FADE_OUT;
                            fading <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= BYPASS;
                    gain   <= '0;
                    fading <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bypass_crossfade.sv
// Bench for bypass_crossfade with FULL=4: vector table plus corner sequences,
// outputs checked through an expected-value queue with latency tracking.
module tb_bypass_crossfade;

    localparam int W  = 24;
    localparam int FL = 2;

    logic                 clk;
    logic                 reset;
    logic                 sample_trig;
    logic                 enable;
    logic signed [W-1:0]  dry_in;
    logic signed [W-1:0]  wet_in;
    logic signed [W-1:0]  data_out;
    logic                 out_valid;
    logic                 fading;
    logic [FL:0]          gain;

    bypass_crossfade #(.W(W), .FADE_LOG2(FL)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_trig (sample_trig),
        .enable      (enable),
        .dry_in      (dry_in),
        .wet_in      (wet_in),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .fading      (fading),
        .gain        (gain)
    );

    typedef struct {
        int en;
        int dry;
        int wet;
        int exp_out;
        int exp_gain;
        int exp_fading;
    } vec_t;

    typedef struct {
        int d;
        int c;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("data_out", 32'(data_out), e.d);
                chk("latency", cyc - e.c, 2);
            end
        end
    end

    function automatic vec_t mk(int en, int d, int w, int o, int g, int f);
        vec_t v;
        v.en = en; v.dry = d; v.wet = w;
        v.exp_out = o; v.exp_gain = g; v.exp_fading = f;
        return v;
    endfunction

    task automatic trig(input int en, input int d, input int w,
                        input bit push, input int eo);
        exp_t e;
        @(negedge clk);
        sample_trig = 1'b1;
        enable      = en[0];
        dry_in      = W'(d);
        wet_in      = W'(w);
        if (push) begin
            e.d = eo;
            e.c = cyc;
            sbq.push_back(e);
        end
        @(negedge clk);
        sample_trig = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        chk("drain", sbq.size(), 0);
    endtask

    initial begin
        reset = 1'b1; sample_trig = 1'b0; enable = 1'b0;
        dry_in = '0; wet_in = '0;

        // idle, full fade in, fade out
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1000, -1000, 1000, 0, 0));
        vecs.push_back(mk(1, 1000, -1000, 1000, 1, 1));
        vecs.push_back(mk(1, 1000, -1000, 500, 2, 1));
        vecs.push_back(mk(1, 1000, -1000, 0, 3, 1));
        vecs.push_back(mk(1, 1000, -1000, -500, 4, 0));
        vecs.push_back(mk(1, 1000, -1000, -1000, 4, 0));
        vecs.push_back(mk(1, 1000, -1000, -1000, 4, 0));
        vecs.push_back(mk(0, 1000, -1000, -1000, 3, 1));
        vecs.push_back(mk(0, 1000, -1000, -500, 2, 1));
        vecs.push_back(mk(0, 1000, -1000, 0, 1, 1));
        vecs.push_back(mk(0, 1000, -1000, 500, 0, 0));
        vecs.push_back(mk(0, 1000, -1000, 1000, 0, 0));
        // reversal mid-fade
        vecs.push_back(mk(1, 1000, -1000, 1000, 1, 1));
        vecs.push_back(mk(1, 1000, -1000, 500, 2, 1));
        vecs.push_back(mk(0, 1000, -1000, 0, 1, 1));
        vecs.push_back(mk(1, 1000, -1000, 500, 2, 1));
        vecs.push_back(mk(0, 1000, -1000, 0, 1, 1));
        vecs.push_back(mk(0, 1000, -1000, 500, 0, 0));
        vecs.push_back(mk(0, 1000, -1000, 1000, 0, 0));
        // floor rounding
        vecs.push_back(mk(1, 0, 3, 0, 1, 1));
        vecs.push_back(mk(1, 0, 3, 0, 2, 1));
        vecs.push_back(mk(0, 0, -3, -2, 1, 1));
        vecs.push_back(mk(0, 0, -3, -1, 0, 0));
        // extremes
        vecs.push_back(mk(1, -8388608, 8388607, -8388608, 1, 1));
        vecs.push_back(mk(1, -8388608, 8388607, -4194305, 2, 1));
        vecs.push_back(mk(1, -8388608, 8388607, -1, 3, 1));
        vecs.push_back(mk(1, -8388608, 8388607, 4194303, 4, 0));
        vecs.push_back(mk(1, -8388608, 8388607, 8388607, 4, 0));
        vecs.push_back(mk(0, 1000, -1000, -1000, 3, 1));
        vecs.push_back(mk(0, 1000, -1000, -500, 2, 1));
        vecs.push_back(mk(0, 1000, -1000, 0, 1, 1));
        vecs.push_back(mk(0, 1000, -1000, 500, 0, 0));

        repeat (3) @(negedge clk);
        chk("reset data_out", 32'(data_out), 0);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset gain", 32'(gain), 0);
        chk("reset fading", 32'(fading), 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            trig(vecs[i].en, vecs[i].dry, vecs[i].wet, 1'b1, vecs[i].exp_out);
            chk($sformatf("vec%0d gain", i), 32'(gain), vecs[i].exp_gain);
            chk($sformatf("vec%0d fading", i), 32'(fading), vecs[i].exp_fading);
        end
        drain();

        // enable toggles without a trigger are ignored
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            enable = ~enable;
        end
        @(negedge clk);
        chk("toggle no trig gain", 32'(gain), 0);

        // back-to-back triggers
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            int d[3] = '{100, 200, -400};
            int w[3] = '{500, 600, 400};
            int o[3] = '{100, 300, 0};
            sample_trig = 1'b1;
            enable = 1'b1;
            dry_in = W'(d[i]);
            wet_in = W'(w[i]);
            e.d = o[i];
            e.c = cyc;
            sbq.push_back(e);
            @(negedge clk);
            chk($sformatf("b2b gain%0d", i), 32'(gain), i + 1);
        end
        sample_trig = 1'b0;
        for (int i = 0; i < 3; i++) trig(0, 0, 0, 1'b1, 0);
        chk("b2b return gain", 32'(gain), 0);
        drain();

        // reset one cycle after a mid-fade trigger
        trig(1, 1000, -1000, 1'b1, 1000);
        trig(1, 1000, -1000, 1'b1, 500);
        drain();
        @(negedge clk);
        sample_trig = 1'b1; enable = 1'b1;
        @(negedge clk);
        sample_trig = 1'b0; reset = 1'b1;
        chk("pre-reset gain", 32'(gain), 3);
        @(negedge clk);
        reset = 1'b0;
        chk("abort out_valid", 32'(out_valid), 0);
        chk("abort data_out", 32'(data_out), 0);
        chk("abort gain", 32'(gain), 0);
        chk("abort fading", 32'(fading), 0);
        repeat (4) @(negedge clk);
        trig(0, 1000, -1000, 1'b1, 1000);
        chk("post-abort gain", 32'(gain), 0);
        drain();

        // reset in the same cycle as a trigger
        trig(1, 1000, -1000, 1'b1, 1000);
        drain();
        @(negedge clk);
        sample_trig = 1'b1; enable = 1'b1; reset = 1'b1;
        @(negedge clk);
        sample_trig = 1'b0; reset = 1'b0;
        chk("reset+trig gain", 32'(gain), 0);
        chk("reset+trig fading", 32'(fading), 0);
        repeat (4) @(negedge clk);
        trig(0, 1000, -1000, 1'b1, 1000);
        chk("reset+trig bypass", 32'(gain), 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
